// File: rtl/id_decode.sv
// RV32I integer-subset decode stage: one instruction per valid/ready handshake,
// registered control/operand fields for the execute ALU, illegal words dropped and counted.
module id_decode #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      inst,
    input  logic [31:0]      pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ex_en,
    output logic [2:0]       aluop,
    output logic             pc_en,
    output logic             imm_en,
    output logic [31:0]      imm,
    output logic [31:0]      pc_out,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic             rd_we,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        ALU_OR  = 3'd0,
        ALU_AND = 3'd1,
        ALU_XOR = 3'd2,
        ALU_ADD = 3'd3,
        ALU_SUB = 3'd4
    } aluop_e;

    typedef struct packed {
        aluop_e      aluop;
        logic        pc_en;
        logic        imm_en;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
    } fields_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       dec_legal;
    fields_t    dec_fld;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        dec_legal      = 1'b0;
        dec_fld.aluop  = ALU_ADD;
        dec_fld.pc_en  = 1'b0;
        dec_fld.imm_en = 1'b0;
        dec_fld.imm    = 32'h0;
        dec_fld.pc     = pc;
        dec_fld.rs1    = inst[19:15];
        dec_fld.rs2    = inst[24:20];
        dec_fld.rd     = inst[11:7];
        dec_fld.rd_we  = 1'b1;
        case (opcode)
            OPC_OP: begin
                // funct7=0100000 is only meaningful as SUB; with any other funct3 it is illegal
                case (funct3)
                    3'b000: begin
                        dec_legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        dec_fld.aluop = inst[30] ? ALU_SUB : ALU_ADD;
                    end
                    3'b100: begin
                        dec_legal     = (funct7 == 7'b0000000);
                        dec_fld.aluop = ALU_XOR;
                    end
                    3'b110: begin
                        dec_legal     = (funct7 == 7'b0000000);
                        dec_fld.aluop = ALU_OR;
                    end
                    3'b111: begin
                        dec_legal     = (funct7 == 7'b0000000);
                        dec_fld.aluop = ALU_AND;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_fld.imm    = {{20{inst[31]}}, inst[31:20]};
                dec_fld.imm_en = 1'b1;
                dec_fld.rs2    = 5'd0;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_fld.aluop = ALU_ADD; end
                    3'b100: begin dec_legal = 1'b1; dec_fld.aluop = ALU_XOR; end
                    3'b110: begin dec_legal = 1'b1; dec_fld.aluop = ALU_OR;  end
                    3'b111: begin dec_legal = 1'b1; dec_fld.aluop = ALU_AND; end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_legal      = 1'b1;
                dec_fld.imm    = {inst[31:12], 12'h000};
                dec_fld.imm_en = 1'b1;
                dec_fld.pc_en  = (opcode == OPC_AUIPC);
                dec_fld.rs1    = 5'd0;
                dec_fld.rs2    = 5'd0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic             out_valid_q, out_valid_d;
    logic             ex_en_q, ex_en_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    fields_t          fld_q, fld_d;
    logic             accept;

    // ex_en term guarantees a low cycle between strobes for the edge-triggered ALU
    assign inst_ready = !rst && (!out_valid_q || out_ready) && !ex_en_q;
    assign accept     = inst_valid && inst_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        ex_en_d       = 1'b0;
        illegal_d     = 1'b0;
        illegal_cnt_d = illegal_cnt_q;
        fld_d         = fld_q;
        if (accept) begin
            if (dec_legal) begin
                fld_d       = dec_fld;
                out_valid_d = 1'b1;
                ex_en_d     = 1'b1;
            end else begin
                out_valid_d   = 1'b0;
                illegal_d     = 1'b1;
                illegal_cnt_d = (illegal_cnt_q == '1) ? illegal_cnt_q
                                                      : illegal_cnt_q + CNT_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            ex_en_q       <= 1'b0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
            fld_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            ex_en_q       <= ex_en_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
            fld_q         <= fld_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign ex_en       = ex_en_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;
    assign aluop       = fld_q.aluop;
    assign pc_en       = fld_q.pc_en;
    assign imm_en      = fld_q.imm_en;
    assign imm         = fld_q.imm;
    assign pc_out      = fld_q.pc;
    assign rs1_addr    = fld_q.rs1;
    assign rs2_addr    = fld_q.rs2;
    assign rd_addr     = fld_q.rd;
    assign rd_we       = fld_q.rd_we;

endmodule

// File: tb/tb_id_decode.sv
// Directed plus random stimulus for id_decode, checked cycle by cycle against
// an instruction-level reference decoder and handshake model.
module tb_id_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, pc;
    logic        out_valid, out_ready, ex_en;
    logic [2:0]  aluop;
    logic        pc_en, imm_en;
    logic [31:0] imm, pc_out;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, illegal;
    logic [7:0]  illegal_cnt;

    always #5 clk = ~clk;

    id_decode #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .ex_en(ex_en), .aluop(aluop), .pc_en(pc_en), .imm_en(imm_en), .imm(imm),
        .pc_out(pc_out), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rd_we(rd_we), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    typedef struct {
        logic        legal;
        logic [2:0]  aluop;
        logic        pc_en, imm_en, rd_we;
        logic [31:0] imm, pc;
        logic [4:0]  rs1, rs2, rd;
    } dec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    dec_t m_fld;
    logic m_valid, m_ex, m_ill;
    int   m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int alu_code(input logic [2:0] f3);
        // 000 add, 100 xor, 110 or, 111 and
        if (f3 == 3'd4) return 2;
        if (f3 == 3'd6) return 0;
        if (f3 == 3'd7) return 1;
        return 3;
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] w, input logic [31:0] p);
        dec_t r;
        int   op, f3, f7, v;
        op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
        r.legal = 1'b0; r.aluop = 3'd3; r.pc_en = 1'b0; r.imm_en = 1'b0; r.rd_we = 1'b1;
        r.imm = 32'h0; r.pc = p; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
        if (op == 'h33) begin
            r.legal = (f7 == 0 && (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7)) ||
                      (f7 == 'h20 && f3 == 0);
            r.aluop = (f3 == 0 && f7 == 'h20) ? 3'd4 : 3'(alu_code(w[14:12]));
        end else if (op == 'h13) begin
            r.legal  = (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7);
            r.aluop  = 3'(alu_code(w[14:12]));
            v = int'(w[31:20]);
            if (v >= 2048) v = v - 4096;
            r.imm    = 32'(v);
            r.imm_en = 1'b1;
            r.rs2    = 5'd0;
        end else if (op == 'h37 || op == 'h17) begin
            r.legal  = 1'b1;
            r.imm    = w & 32'hFFFF_F000;
            r.imm_en = 1'b1;
            r.pc_en  = (op == 'h17);
            r.rs1    = 5'd0;
            r.rs2    = 5'd0;
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int sel, f7sel;
        w = $urandom;
        sel = $urandom_range(0, 5);
        f7sel = $urandom_range(0, 2);
        case (sel)
            0: begin
                w[6:0] = 7'h33;
                if (f7sel == 0) w[31:25] = 7'h00;
                else if (f7sel == 1) w[31:25] = 7'h20;
            end
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_outputs();
        chk("out_valid",   32'(out_valid),   32'(m_valid));
        chk("ex_en",       32'(ex_en),       32'(m_ex));
        chk("illegal",     32'(illegal),     32'(m_ill));
        chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
        chk("aluop",       32'(aluop),       32'(m_fld.aluop));
        chk("pc_en",       32'(pc_en),       32'(m_fld.pc_en));
        chk("imm_en",      32'(imm_en),      32'(m_fld.imm_en));
        chk("imm",         imm,              m_fld.imm);
        chk("pc_out",      pc_out,           m_fld.pc);
        chk("rs1_addr",    32'(rs1_addr),    32'(m_fld.rs1));
        chk("rs2_addr",    32'(rs2_addr),    32'(m_fld.rs2));
        chk("rd_addr",     32'(rd_addr),     32'(m_fld.rd));
        chk("rd_we",       32'(rd_we),       32'(m_fld.rd_we));
    endtask

    task automatic step(input logic iv, input logic [31:0] w, input logic [31:0] p,
                        input logic ordy);
        dec_t d;
        logic rdy, acc;
        inst_valid = iv; inst = w; pc = p; out_ready = ordy;
        #1;
        rdy = (!m_valid || ordy) && !m_ex;
        chk("inst_ready", 32'(inst_ready), 32'(rdy));
        acc = iv && rdy;
        d = ref_dec(w, p);
        @(posedge clk);
        m_ex = 1'b0; m_ill = 1'b0;
        if (acc) begin
            if (d.legal) begin
                m_fld = d; m_valid = 1'b1; m_ex = 1'b1;
            end else begin
                m_valid = 1'b0; m_ill = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_valid = 1'b1; inst = 32'h002081B3; out_ready = 1'b1;
        #1;
        chk("ready_in_reset", 32'(inst_ready), 32'd0);
        @(posedge clk);
        m_fld = '{default: '0}; m_valid = 1'b0; m_ex = 1'b0; m_ill = 1'b0; m_cnt = 0;
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] p);
        step(1'b1, w, p, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst = 32'h0; pc = 32'h0; out_ready = 1'b0;
        m_fld = '{default: '0}; m_valid = 1'b0; m_ex = 1'b0; m_ill = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        do_reset();

        // add x3,x1,x2
        step(1'b1, 32'h002081B3, 32'h100, 1'b1);
        chk("add_aluop", 32'(aluop), 32'd3);
        chk("add_ex_en", 32'(ex_en), 32'd1);
        chk("add_rd",    32'(rd_addr), 32'd3);
        step(1'b1, 32'h402081B3, 32'h104, 1'b1);   // blocked by ex_en
        chk("ex_en_drop", 32'(ex_en), 32'd0);
        issue(32'h402081B3, 32'h104);
        issue(32'hFFF00293, 32'h108);
        issue(32'h123453B7, 32'h10C);
        issue(32'h00001417, 32'h200);
        chk("auipc_imm", imm, 32'h0000_1000);
        chk("auipc_pc",  pc_out, 32'h200);

        // sll is unsupported
        step(1'b1, 32'h001090B3, 32'h204, 1'b1);
        chk("sll_illegal", 32'(illegal), 32'd1);
        chk("sll_cnt",     32'(illegal_cnt), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 32'h001090B3, 32'h0, 1'b1);
        chk("cnt_saturated", 32'(illegal_cnt), 32'hFF);

        // downstream stall then release with simultaneous consume+accept
        step(1'b1, 32'h002081B3, 32'h300, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0020C1B3, 32'h304, 1'b0);
        chk("stall_pc", pc_out, 32'h300);
        step(1'b1, 32'h0020C1B3, 32'h304, 1'b1);
        step(1'b1, 32'h0020E1B3, 32'h308, 1'b1);
        step(1'b1, 32'h0020E1B3, 32'h308, 1'b1);

        // reset with a held instruction
        step(1'b1, 32'h123453B7, 32'h400, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        do_reset();
        issue(32'h002081B3, 32'h500);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) != 0), gen_inst(), $urandom,
                 1'($urandom_range(0, 3) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
